pc_sequencer: RTL and testbench

Program-counter sequencer for the 8227 core. It owns the 16-bit PC register and applies every update the instruction stream requests: sequential increment, absolute jump load, relative branch with page-cross fix-up, and two-cycle vector fetch for reset/NMI/IRQ. It sits between the control unit, which issues one-cycle requests, and the memory interface, which returns vector bytes. It replaces ad-hoc PC arithmetic in the control path with a single sequenced owner.

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - 16-bit program-counter sequencer with branch fix-up and vector fetch
module pc_sequencer (
    input  logic       clk,
    input  logic       nrst,
    input  logic       fetch,
    input  logic       jump_load,
    input  logic [7:0] jump_low,
    input  logic [7:0] jump_high,
    input  logic       branch_take,
    input  logic [7:0] branch_offset,
    input  logic       vector_req,
    input  logic [1:0] vector_sel,
    input  logic [7:0] mem_data,
    output logic [7:0] pc_low,
    output logic [7:0] pc_high,
    output logic       vec_active,
    output logic [7:0] vec_addr_low,
    output logic [7:0] vec_addr_high,
    output logic       busy,
    output logic       vector_done
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_BRANCH_FIX = 2'd1,
        S_VEC_LO     = 2'd2,
        S_VEC_HI     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  base_q, base_d;
    logic        dir_up_q, dir_up_d;
    logic        vector_done_q, vector_done_d;
    logic [8:0]  branch_sum;

    // State register; reset drops straight into the reset-vector fetch
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= S_VEC_LO;
            pc_q          <= 16'h0000;
            base_q        <= 8'hFC;
            dir_up_q      <= 1'b0;
            vector_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            base_q        <= base_d;
            dir_up_q      <= dir_up_d;
            vector_done_q <= vector_done_d;
        end
    end

    // Next-state and PC update; one action per idle cycle, lower-priority requests dropped
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        base_d        = base_q;
        dir_up_d      = dir_up_q;
        vector_done_d = 1'b0;
        branch_sum    = {1'b0, pc_q[7:0]} + {1'b0, branch_offset};

        case (state_q)
            S_IDLE: begin
                if (vector_req) begin
                    case (vector_sel)
                        2'd0:    base_d = 8'hFA;
                        2'd1:    base_d = 8'hFC;
                        default: base_d = 8'hFE;
                    endcase
                    state_d = S_VEC_LO;
                end else if (jump_load) begin
                    pc_d = {jump_high, jump_low};
                end else if (branch_take) begin
                    // Low byte lands now; a carry/borrow out of the page defers the
                    // high-byte correction by one cycle, like the 6502 dummy read.
                    pc_d[7:0] = branch_sum[7:0];
                    if (!branch_offset[7] && branch_sum[8]) begin
                        dir_up_d = 1'b1;
                        state_d  = S_BRANCH_FIX;
                    end else if (branch_offset[7] && !branch_sum[8]) begin
                        dir_up_d = 1'b0;
                        state_d  = S_BRANCH_FIX;
                    end
                end else if (fetch) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            S_BRANCH_FIX: begin
                pc_d[15:8] = dir_up_q ? (pc_q[15:8] + 8'd1) : (pc_q[15:8] - 8'd1);
                state_d    = S_IDLE;
            end
            S_VEC_LO: begin
                pc_d[7:0] = mem_data;
                state_d   = S_VEC_HI;
            end
            default: begin
                pc_d[15:8]    = mem_data;
                state_d       = S_IDLE;
                vector_done_d = 1'b1;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        pc_low        = pc_q[7:0];
        pc_high       = pc_q[15:8];
        vec_addr_high = 8'hFF;
        busy          = (state_q != S_IDLE);
        vec_active    = (state_q == S_VEC_LO) || (state_q == S_VEC_HI);
        vector_done   = vector_done_q;
        case (state_q)
            S_VEC_LO: vec_addr_low = base_q;
            S_VEC_HI: vec_addr_low = base_q + 8'd1;
            default:  vec_addr_low = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       fetch, jump_load, branch_take, vector_req;
    logic [7:0] jump_low, jump_high, branch_offset, mem_data;
    logic [1:0] vector_sel;
    logic [7:0] pc_low, pc_high, vec_addr_low, vec_addr_high;
    logic       vec_active, busy, vector_done;

    pc_sequencer dut (
        .clk           (clk),
        .nrst          (nrst),
        .fetch         (fetch),
        .jump_load     (jump_load),
        .jump_low      (jump_low),
        .jump_high     (jump_high),
        .branch_take   (branch_take),
        .branch_offset (branch_offset),
        .vector_req    (vector_req),
        .vector_sel    (vector_sel),
        .mem_data      (mem_data),
        .pc_low        (pc_low),
        .pc_high       (pc_high),
        .vec_active    (vec_active),
        .vec_addr_low  (vec_addr_low),
        .vec_addr_high (vec_addr_high),
        .busy          (busy),
        .vector_done   (vector_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic        busy;
        logic        act;
        logic [7:0]  alo;
        logic        vd;
        string       name;
    } obs_t;

    obs_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] m_pc;
    string       cur_name;

    // Expected observation for the cycle after the current edge
    function automatic void expect_obs(logic [15:0] pc, logic b, logic a, logic [7:0] alo, logic vd);
        obs_t o;
        o.cyc  = cyc + 1;
        o.pc   = pc;
        o.busy = b;
        o.act  = a;
        o.alo  = alo;
        o.vd   = vd;
        o.name = cur_name;
        exp_q.push_back(o);
    endfunction

    // Monitor: compare DUT outputs against the scoreboard once per cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            obs_t e;
            e = exp_q.pop_front();
            vectors++;
            if (e.cyc != cyc || {pc_high, pc_low} !== e.pc || busy !== e.busy ||
                vec_active !== e.act || vec_addr_low !== e.alo || vec_addr_high !== 8'hFF ||
                vector_done !== e.vd) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got pc=%h busy=%b act=%b addr=%h%h vd=%b, expected pc=%h busy=%b act=%b addr=FF%h vd=%b",
                         e.name, cyc, {pc_high, pc_low}, busy, vec_active, vec_addr_high, vec_addr_low,
                         vector_done, e.pc, e.busy, e.act, e.alo, e.vd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        fetch       = 1'b0;
        jump_load   = 1'b0;
        branch_take = 1'b0;
        vector_req  = 1'b0;
    endtask

    task automatic junk();
        fetch         = 1'($urandom);
        jump_load     = 1'($urandom);
        branch_take   = 1'($urandom);
        vector_req    = 1'($urandom);
        jump_low      = 8'($urandom);
        jump_high     = 8'($urandom);
        branch_offset = 8'($urandom);
        vector_sel    = 2'($urandom);
        mem_data      = 8'($urandom);
    endtask

    task automatic apply_reset_cycle();
        junk();
        nrst = 1'b0;
        m_pc = 16'h0000;
        expect_obs(16'h0000, 1'b1, 1'b1, 8'hFC, 1'b0);
        tick();
    endtask

    // Remaining vector cycles, starting in the cycle that reads the low byte
    task automatic vec_tail(logic [7:0] base, logic [7:0] lo, logic [7:0] hi, bit rst_in_hi);
        junk();
        nrst     = 1'b1;
        mem_data = lo;
        m_pc     = {m_pc[15:8], lo};
        expect_obs(m_pc, 1'b1, 1'b1, base + 8'd1, 1'b0);
        tick();
        if (rst_in_hi) begin
            apply_reset_cycle();
            vec_tail(8'hFC, 8'($urandom), 8'($urandom), 1'b0);
        end else begin
            junk();
            fetch    = 1'b1;
            mem_data = hi;
            m_pc     = {hi, lo};
            expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b1);
            tick();
        end
    endtask

    task automatic do_reset(int n, logic [7:0] lo, logic [7:0] hi);
        cur_name = "reset";
        for (int i = 0; i < n; i++) apply_reset_cycle();
        vec_tail(8'hFC, lo, hi, 1'b0);
    endtask

    task automatic op_idle();
        cur_name = "idle";
        clear_req();
        expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic op_fetch();
        cur_name = "fetch";
        clear_req();
        fetch = 1'b1;
        m_pc  = m_pc + 16'd1;
        expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic op_jump(logic [7:0] hi, logic [7:0] lo);
        cur_name = "jump";
        clear_req();
        jump_load     = 1'b1;
        jump_high     = hi;
        jump_low      = lo;
        branch_take   = 1'($urandom);
        branch_offset = 8'($urandom);
        fetch         = 1'($urandom);
        m_pc          = {hi, lo};
        expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic op_branch(logic [7:0] off, bit rst_in_fix);
        logic [15:0] tgt;
        cur_name = "branch";
        clear_req();
        branch_take   = 1'b1;
        branch_offset = off;
        fetch         = 1'($urandom);
        tgt = m_pc + {{8{off[7]}}, off};
        if (tgt[15:8] == m_pc[15:8]) begin
            m_pc = tgt;
            expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end else begin
            cur_name = "branch_cross";
            m_pc = {m_pc[15:8], tgt[7:0]};
            expect_obs(m_pc, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            if (rst_in_fix) begin
                cur_name = "reset_in_fix";
                apply_reset_cycle();
                vec_tail(8'hFC, 8'($urandom), 8'($urandom), 1'b0);
            end else begin
                junk();
                m_pc = tgt;
                expect_obs(m_pc, 1'b0, 1'b0, 8'h00, 1'b0);
                tick();
            end
        end
    endtask

    task automatic op_vector(logic [1:0] sel, logic [7:0] lo, logic [7:0] hi, bit rst_in_hi);
        logic [7:0] base;
        cur_name = "vector";
        base = (sel == 2'd0) ? 8'hFA : (sel == 2'd1) ? 8'hFC : 8'hFE;
        clear_req();
        vector_req    = 1'b1;
        vector_sel    = sel;
        jump_load     = 1'b1;
        jump_high     = 8'($urandom);
        jump_low      = 8'($urandom);
        fetch         = 1'b1;
        branch_take   = 1'($urandom);
        branch_offset = 8'($urandom);
        expect_obs(m_pc, 1'b1, 1'b1, base, 1'b0);
        tick();
        if (rst_in_hi) cur_name = "reset_in_vec_hi";
        vec_tail(base, lo, hi, rst_in_hi);
    endtask

    initial begin
        nrst = 1'b0;
        clear_req();
        jump_low = 8'h00; jump_high = 8'h00; branch_offset = 8'h00;
        vector_sel = 2'd0; mem_data = 8'h00;
        m_pc = 16'h0000;
        cur_name = "init";

        do_reset(2, 8'h34, 8'h12);
        op_idle();
        op_jump(8'hFF, 8'hFE);
        op_fetch();
        op_fetch();
        op_jump(8'h10, 8'h80);
        op_branch(8'h10, 1'b0);
        op_branch(8'hF0, 1'b0);
        op_jump(8'h10, 8'hF0);
        op_branch(8'h20, 1'b0);
        op_jump(8'h00, 8'h05);
        op_branch(8'hF0, 1'b0);
        op_vector(2'd0, 8'h78, 8'h56, 1'b0);
        op_jump(8'h10, 8'hF0);
        op_branch(8'h20, 1'b1);
        op_vector(2'd0, 8'h22, 8'h11, 1'b1);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       do_reset($urandom_range(1, 3), 8'($urandom), 8'($urandom));
            else if (r < 15) op_vector(2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
            else if (r < 35) op_jump(8'($urandom), 8'($urandom));
            else if (r < 60) op_branch(8'($urandom), ($urandom_range(0, 9) == 0));
            else if (r < 85) op_fetch();
            else             op_idle();
        end
        op_idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
